// File: rtl/bit_equality_unit.sv
// rtl/bit_equality_unit.sv - registered N-bit equality comparator with sticky mismatch tracking
// One-cycle-latency compare; a mismatch in the same cycle as clr_sticky leaves a fresh count of one.
module bit_equality_unit #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clr_sticky,
  output logic             z,
  output logic [WIDTH-1:0] eq_bits,
  output logic             valid,
  output logic             mismatch_seen,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             z_q, z_d;
  logic [WIDTH-1:0] eq_bits_q, eq_bits_d;
  logic             valid_q, valid_d;
  logic             mismatch_seen_q, mismatch_seen_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             mismatch;

  always_comb begin
    z_d             = z_q;
    eq_bits_d       = eq_bits_q;
    valid_d         = en;
    mismatch_seen_d = mismatch_seen_q;
    mismatch_cnt_d  = mismatch_cnt_q;
    mismatch        = en && (A != B);

    if (en) begin
      eq_bits_d = ~(A ^ B);
      z_d       = (A == B);
    end

    if (mismatch) begin
      mismatch_seen_d = 1'b1;
      if (clr_sticky) begin
        mismatch_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (mismatch_cnt_q != CNT_MAX) begin
        mismatch_cnt_d = mismatch_cnt_q + 1'b1;
      end
    end else if (clr_sticky) begin
      mismatch_seen_d = 1'b0;
      mismatch_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q             <= 1'b0;
      eq_bits_q       <= '0;
      valid_q         <= 1'b0;
      mismatch_seen_q <= 1'b0;
      mismatch_cnt_q  <= '0;
    end else begin
      z_q             <= z_d;
      eq_bits_q       <= eq_bits_d;
      valid_q         <= valid_d;
      mismatch_seen_q <= mismatch_seen_d;
      mismatch_cnt_q  <= mismatch_cnt_d;
    end
  end

  assign z             = z_q;
  assign eq_bits       = eq_bits_q;
  assign valid         = valid_q;
  assign mismatch_seen = mismatch_seen_q;
  assign mismatch_cnt  = mismatch_cnt_q;

endmodule

// File: tb/tb_bit_equality_unit.sv
// tb/tb_bit_equality_unit.sv - scoreboard bench for bit_equality_unit
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_bit_equality_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] A = '0;
  logic [1:0] B = '0;
  logic       clr_sticky = 1'b0;

  logic       z8, v8, s8, z2, v2, s2;
  logic [1:0] eq8, eq2;
  logic [7:0] c8;
  logic [1:0] c2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       z;
    logic [1:0] eq;
    logic       v;
    logic       seen;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model state
  bit       m_z;
  bit [1:0] m_eq;
  bit       m_seen;
  int       m_c8, m_c2;
  bit       done = 1'b0;

  bit_equality_unit #(.WIDTH(2), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .clr_sticky(clr_sticky),
    .z(z8), .eq_bits(eq8), .valid(v8), .mismatch_seen(s8), .mismatch_cnt(c8)
  );

  bit_equality_unit #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .clr_sticky(clr_sticky),
    .z(z2), .eq_bits(eq2), .valid(v2), .mismatch_seen(s2), .mismatch_cnt(c2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat_inc(input int c, input int maxv);
    return (c >= maxv) ? maxv : c + 1;
  endfunction

  task automatic step(input bit r, input bit e, input bit [1:0] a, input bit [1:0] b, input bit c);
    exp_t x;
    bit mis;
    @(negedge clk);
    rst = r; en = e; A = a; B = b; clr_sticky = c;
    mis = e && (a != b);
    if (r) begin
      m_z = 0; m_eq = 0; m_seen = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      if (e) begin
        m_z = (a == b);
        for (int i = 0; i < 2; i++) m_eq[i] = (a[i] == b[i]);
      end
      if (mis) begin
        m_seen = 1;
        m_c8 = c ? 1 : sat_inc(m_c8, 255);
        m_c2 = c ? 1 : sat_inc(m_c2, 3);
      end else if (c) begin
        m_seen = 0; m_c8 = 0; m_c2 = 0;
      end
    end
    x.z = m_z; x.eq = m_eq; x.v = e && !r; x.seen = m_seen;
    x.c8 = 8'(m_c8); x.c2 = 2'(m_c2);
    exp_q.push_back(x);
  endtask

  // monitor: pops one expectation per clock edge once stimulus has queued one
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      chk("z_and_reduce8", z8, &eq8);
      chk("z_and_reduce2", z2, &eq2);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("z", z8, x.z);
        chk("eq_bits", eq8, x.eq);
        chk("valid", v8, x.v);
        chk("mismatch_seen", s8, x.seen);
        chk("mismatch_cnt8", c8, x.c8);
        chk("z_w2", z2, x.z);
        chk("eq_bits_w2", eq2, x.eq);
        chk("valid_w2", v2, x.v);
        chk("mismatch_seen_w2", s2, x.seen);
        chk("mismatch_cnt2", c2, x.c2);
      end else if (!done && (v8 || v2)) begin
        chk("valid_unexpected", {v8, v2}, 2'b00);
      end
    end
  end

  initial begin
    // reset held with a mismatching compare on the inputs
    step(1, 1, 2'b01, 2'b10, 0);
    step(1, 1, 2'b01, 2'b10, 0);
    // equality sequence
    step(0, 1, 2'b00, 2'b00, 0);
    step(0, 1, 2'b01, 2'b01, 0);
    step(0, 1, 2'b10, 2'b00, 0);
    step(0, 1, 2'b11, 2'b10, 0);
    // hold with toggling operands
    for (int i = 0; i < 4; i++) step(0, 0, 2'($urandom), 2'($urandom), 0);
    // clear, then clear colliding with a mismatch
    step(0, 0, 2'b01, 2'b10, 1);
    step(0, 1, 2'b11, 2'b00, 1);
    step(0, 0, 2'b00, 2'b00, 1);
    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 2'b10, 0);
    // exhaustive operand pairs
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        step(0, 1, 2'(a), 2'(b), 0);
    // randomized traffic including mid-stream resets
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 19) == 0, 1'($urandom), 2'($urandom), 2'($urandom),
           $urandom_range(0, 9) == 0);
    step(0, 0, 2'b00, 2'b00, 0);
    @(negedge clk);
    en = 0; clr_sticky = 0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_equality_unit.md
Name: bit_equality_unit

Overview:
Registered N-bit equality comparator (default 2 bits) for operand-match checks in the datapath. Samples A and B on an enable and registers a 1-bit equal flag z plus per-bit match bits. Also keeps a sticky mismatch flag and a saturating mismatch counter for status and debug readout.

Parameters:
WIDTH, 2, operand width in bits (legal range 1 to 64).
CNT_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  compare strobe; A and B are sampled on a clk edge when en=1.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
clr_sticky  input  1  synchronous clear of mismatch_seen and mismatch_cnt.
z  output  WIDTH-independent 1  registered equality result: 1 when A==B.
eq_bits  output  WIDTH  registered per-bit match, bit i = ~(A[i]^B[i]).
valid  output  1  one-cycle pulse marking new z/eq_bits.
mismatch_seen  output  1  sticky flag, set by any compare with A!=B.
mismatch_cnt  output  CNT_W  saturating count of compares with A!=B.

Behaviour:
- All state updates on rising clk. rst is synchronous, active-high, and has priority over every other input.
- Reset values: z=0, eq_bits=0, valid=0, mismatch_seen=0, mismatch_cnt=0.
- Latency is 1 cycle. When en=1 at edge k:
  - z is set to (A==B) for the sampled values.
  - eq_bits is set to ~(A^B).
  - valid is 1 during the cycle after edge k.
- When en=0: z and eq_bits hold their last values, and valid=0.
- Back-to-back en=1 gives a new result every cycle, and valid stays high.
- z equals the AND-reduction of eq_bits at all times.
- Comparison is unsigned bitwise. Operands are exactly WIDTH bits; wider source values are truncated upstream.
- Mismatch tracking: on en=1 with A!=B, mismatch_seen is set to 1 and mismatch_cnt increments by 1.
- mismatch_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_sticky=1 with no mismatch that cycle: mismatch_seen=0 and mismatch_cnt=0 at the next edge.
- clr_sticky=1 with en=1 and A!=B in the same cycle: the mismatch wins. Result is mismatch_seen=1 and mismatch_cnt=1.
- clr_sticky does not affect z, eq_bits or valid.
- Reset mid-stream: any compare in progress is discarded, and outputs return to reset values on that edge.
- Purely synchronous design: no latches, no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1 and A=2'b01, B=2'b10 -> z=0, eq_bits=00, valid=0, mismatch_seen=0, mismatch_cnt=0.
- Equality sequence, one compare per cycle with en=1:
  - (A,B)=(00,00) -> z=1, eq_bits=11.
  - (01,01) -> z=1, eq_bits=11.
  - (10,00) -> z=0, eq_bits=01.
  - (11,10) -> z=0, eq_bits=10.
  - Each result appears 1 cycle later with valid=1; afterwards mismatch_cnt=2 and mismatch_seen=1.
- Hold: en=0 while A and B toggle freely -> z and eq_bits unchanged, valid=0, mismatch_cnt unchanged.
- Clear/priority:
  - clr_sticky=1 with en=0 -> mismatch_seen=0, cnt=0.
  - clr_sticky=1 with en=1 and A=11, B=00 -> mismatch_seen=1, cnt=1.
- Saturation (CNT_W=2): 5 consecutive mismatching compares -> mismatch_cnt sequence 1,2,3,3,3.
- Exhaustive: all 16 (A,B) pairs for WIDTH=2 -> z=1 only for the 4 equal pairs, and z always equals &eq_bits.
